// File: rtl/data_mem_responder.sv
// Data-memory slave for the single-cycle core: synchronous byte/half/word stores and combinational sign-extended loads.
// A clear engine zeroes the array after reset. Define DMEM_MISALIGN_TRAP_EN to trap misaligned or reserved-size accesses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MemAddr,
  input  logic [31:0] toMem,
  input  logic        WriteEn,
  input  logic        ReadEn,
  input  logic [1:0]  addMemControl,
  output logic [31:0] fromMem,
  output logic        busy,
  output logic        fault,
  output logic [31:0] faultAddr
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_t        r_state;
  logic [AW-1:0] r_clrIdx;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic          w_ready;
  logic          w_access;
  logic          w_blocked;
  logic          w_storeEn;
  logic [3:0]    w_byteEn;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rdWord;
  logic [31:0]   w_merged;
  logic [7:0]    w_rdByte;
  logic [15:0]   w_rdHalf;
  logic [31:0]   w_loadData;
  logic          w_unusedAddr;

  // Upper address bits alias onto the array.
  assign w_idx        = MemAddr[AW+1:2];
  assign w_unusedAddr = ^MemAddr[31:AW+2];
  assign w_ready      = (r_state == READY);
  assign w_access     = ReadEn | WriteEn;
  assign busy         = (r_state == CLEAR);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_blocked = (addMemControl == 2'b11) ||
                     ((addMemControl == 2'b01) && MemAddr[0]) ||
                     ((addMemControl == 2'b10) && (MemAddr[1:0] != 2'b00));
`else
  assign w_blocked = (addMemControl == 2'b11);
`endif

  assign w_storeEn = w_ready & WriteEn & ~w_blocked;

  always_comb begin
    w_byteEn = 4'b0000;
    w_wdata  = toMem;
    case (addMemControl)
      2'b00: begin
        w_byteEn = 4'b0001 << MemAddr[1:0];
        w_wdata  = {4{toMem[7:0]}};
      end
      2'b01: begin
        w_byteEn = MemAddr[1] ? 4'b1100 : 4'b0011;
        w_wdata  = {2{toMem[15:0]}};
      end
      2'b10: begin
        w_byteEn = 4'b1111;
        w_wdata  = toMem;
      end
      default: begin
        w_byteEn = 4'b0000;
        w_wdata  = toMem;
      end
    endcase
  end

  assign w_rdWord = r_mem[w_idx];

  always_comb begin
    w_merged = w_rdWord;
    for (int k = 0; k < 4; k++) begin
      if (w_byteEn[k]) begin
        w_merged[8*k +: 8] = w_wdata[8*k +: 8];
      end
    end
  end

  assign w_rdByte = w_rdWord[{MemAddr[1:0], 3'b000} +: 8];
  assign w_rdHalf = w_rdWord[{MemAddr[1], 4'b0000} +: 16];

  always_comb begin
    w_loadData = 32'h0;
    case (addMemControl)
      2'b00:   w_loadData = {{24{w_rdByte[7]}}, w_rdByte};
      2'b01:   w_loadData = {{16{w_rdHalf[15]}}, w_rdHalf};
      2'b10:   w_loadData = w_rdWord;
      default: w_loadData = 32'h0;
    endcase
  end

  assign fromMem = (w_ready && ReadEn && !w_blocked) ? w_loadData : 32'h0;

  // Reset only restarts the clear sweep; the array itself is zeroed one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= CLEAR;
      r_clrIdx <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_mem[r_clrIdx] <= 32'h0;
          r_clrIdx        <= r_clrIdx + 1'b1;
          if (r_clrIdx == LAST_IDX) begin
            r_state <= READY;
          end
        end
        READY: begin
          if (w_storeEn) begin
            r_mem[w_idx] <= w_merged;
          end
        end
        default: begin
          r_state  <= CLEAR;
          r_clrIdx <= '0;
        end
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic        r_fault;
  logic [31:0] r_faultAddr;

  // Sticky trap: the first offending address is kept until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault     <= 1'b0;
      r_faultAddr <= 32'h0;
    end else if (w_ready && w_access && w_blocked) begin
      r_fault <= 1'b1;
      if (!r_fault) begin
        r_faultAddr <= MemAddr;
      end
    end
  end

  assign fault     = r_fault;
  assign faultAddr = r_faultAddr;
`else
  assign fault     = 1'b0;
  assign faultAddr = 32'h0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: clear engine, word/byte/half paths, aliasing,
// same-cycle read/write, reserved size and (with DMEM_MISALIGN_TRAP_EN) the misalignment trap.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] MemAddr;
  logic [31:0] toMem;
  logic        WriteEn;
  logic        ReadEn;
  logic [1:0]  addMemControl;
  logic [31:0] fromMem;
  logic        busy;
  logic        fault;
  logic [31:0] faultAddr;

  int nAssert = 0;
  int nFail   = 0;
  int clrCycles;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic [31:0] WORD10_FINAL = 32'h8001BEEF;
`else
  localparam logic [31:0] WORD10_FINAL = 32'h80015555;
`endif

  data_mem_responder #(.DEPTH_WORDS(256), .AW(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .MemAddr       (MemAddr),
    .toMem         (toMem),
    .WriteEn       (WriteEn),
    .ReadEn        (ReadEn),
    .addMemControl (addMemControl),
    .fromMem       (fromMem),
    .busy          (busy),
    .fault         (fault),
    .faultAddr     (faultAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAssert++;
    if (observed !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge, then settle for 1 time unit before any check.
  task automatic applyStimulus(input logic we, input logic re, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    WriteEn       = we;
    ReadEn        = re;
    addMemControl = size;
    MemAddr       = addr;
    toMem         = data;
    #1;
  endtask

  task automatic doLoad(input string tag, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] expected);
    applyStimulus(1'b0, 1'b1, size, addr, 32'h0);
    checkOutput(tag, fromMem, expected);
  endtask

  // Drops reset and counts falling edges with busy high; optionally pokes a write during the clear.
  task automatic waitClear(input bit probe, output int cycles);
    rst     = 1'b0;
    cycles  = 0;
    while (busy === 1'b1 && cycles < 1000) begin
      if (probe && cycles == 10) begin
        WriteEn = 1'b1; ReadEn = 1'b1; addMemControl = SZ_W; MemAddr = 32'h0; toMem = 32'hFFFF_FFFF;
        #1;
        checkOutput("busyLoadZero", fromMem, 32'h0);
      end else begin
        WriteEn = 1'b0; ReadEn = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    WriteEn = 1'b0; ReadEn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; WriteEn = 1'b0; ReadEn = 1'b0; addMemControl = SZ_W; MemAddr = 32'h0; toMem = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("resetBusy", {31'h0, busy}, 32'h1);
    checkOutput("resetFault", {31'h0, fault}, 32'h0);
    checkOutput("resetFaultAddr", faultAddr, 32'h0);

    waitClear(1'b1, clrCycles);
    checkOutput("clearCycles", clrCycles, 32'd256);
    checkOutput("busyLow", {31'h0, busy}, 32'h0);

    doLoad("clrWord0", SZ_W, 32'h0000_0000, 32'h0);
    doLoad("clrWord5", SZ_W, 32'h0000_0014, 32'h0);
    doLoad("clrWord255", SZ_W, 32'h0000_03FC, 32'h0);

    applyStimulus(1'b1, 1'b0, SZ_W, 32'h10, 32'hDEAD_BEEF);
    doLoad("lw10", SZ_W, 32'h10, 32'hDEAD_BEEF);
    doLoad("lwAlias410", SZ_W, 32'h410, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 1'b0, SZ_B, 32'h13, 32'h1234_567F);
    doLoad("lwAfterSb", SZ_W, 32'h10, 32'h7FAD_BEEF);
    doLoad("lb11", SZ_B, 32'h11, 32'hFFFF_FFBE);
    doLoad("lb13", SZ_B, 32'h13, 32'h0000_007F);

    applyStimulus(1'b1, 1'b0, SZ_H, 32'h12, 32'hABCD_8001);
    doLoad("lwAfterSh", SZ_W, 32'h10, 32'h8001_BEEF);
    doLoad("lh12", SZ_H, 32'h12, 32'hFFFF_8001);
    doLoad("lh10", SZ_H, 32'h10, 32'hFFFF_BEEF);

    applyStimulus(1'b0, 1'b0, SZ_W, 32'h10, 32'h0);
    checkOutput("readEnLow", fromMem, 32'h0);

    applyStimulus(1'b1, 1'b1, SZ_W, 32'h20, 32'h1234_5678);
    checkOutput("rwOldData", fromMem, 32'h0);
    doLoad("rwNewData", SZ_W, 32'h20, 32'h1234_5678);

`ifdef DMEM_MISALIGN_TRAP_EN
    checkOutput("noFaultYet", {31'h0, fault}, 32'h0);
    applyStimulus(1'b1, 1'b0, SZ_W, 32'h22, 32'hFFFF_FFFF);
    doLoad("trapWordKept", SZ_W, 32'h20, 32'h1234_5678);
    checkOutput("trapFault", {31'h0, fault}, 32'h1);
    checkOutput("trapAddr", faultAddr, 32'h22);
    doLoad("trapLhZero", SZ_H, 32'h31, 32'h0);
    applyStimulus(1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
    checkOutput("trapAddrKept", faultAddr, 32'h22);
    checkOutput("trapFaultSticky", {31'h0, fault}, 32'h1);
`else
    doLoad("lhForcedAlign", SZ_H, 32'h13, 32'hFFFF_8001);
    doLoad("lwForcedAlign", SZ_W, 32'h13, 32'h8001_BEEF);
    applyStimulus(1'b1, 1'b0, SZ_H, 32'h11, 32'h0000_5555);
    doLoad("shForcedAlign", SZ_W, 32'h10, 32'h8001_5555);
    checkOutput("faultTied", {31'h0, fault}, 32'h0);
    checkOutput("faultAddrTied", faultAddr, 32'h0);
`endif

    doLoad("reservedLoad", SZ_R, 32'h10, 32'h0);
    applyStimulus(1'b1, 1'b0, SZ_R, 32'h10, 32'h0);
    doLoad("reservedNoStore", SZ_W, 32'h10, WORD10_FINAL);

    // Reset partway through a clear must restart the full sweep.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("midClearBusy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstClearsFault", {31'h0, fault}, 32'h0);
    checkOutput("rstClearsFaultAddr", faultAddr, 32'h0);
    waitClear(1'b0, clrCycles);
    checkOutput("restartCycles", clrCycles, 32'd256);
    doLoad("reclearWord10", SZ_W, 32'h10, 32'h0);
    doLoad("reclearWord20", SZ_W, 32'h20, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
